// File: rtl/load_unit.sv
// load_unit: multi-cycle MIPS load path. Decodes an I-type load, forms
// base + sext(imm16), issues one ready-handshaked memory read, then
// extracts/extends the addressed byte, halfword or word and drives the
// register-file write port. Every output is registered.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; decodes and checks alignment on start
//   REQ   | mem_read high, address held, waiting for mem_ready
//   WB    | one-cycle done pulse with write-back of extracted data
//   ERR   | one-cycle done+error pulse (decode, alignment, timeout)
module load_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] instruction,
   input  logic [31:0] Read_data1,
   output logic        busy,
   output logic        mem_read,
   output logic [31:0] mem_address,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        reg_write,
   output logic [4:0]  write_register,
   output logic [31:0] write_data,
   output logic        done,
   output logic        error
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;

   localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, REQ, WB, ERR} state_t;

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n, cnt_inc;
   logic [5:0]  op_q, op_n;
   logic [4:0]  rt_q, rt_n;
   logic [1:0]  lane_q, lane_n;
   logic [31:0] ea;

   logic        busy_n, mem_read_n, reg_write_n, done_n, error_n;
   logic [31:0] mem_address_n, write_data_n;
   logic [4:0]  write_register_n;

   // Select the addressed field from the returned word and extend it.
   function automatic logic [31:0] extract(input logic [5:0] op,
                                           input logic [1:0] lane,
                                           input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lane[1] ? w[31:16] : w[15:0];
      case (op)
         OP_LB:   r = {{24{b[7]}}, b};
         OP_LBU:  r = {24'd0, b};
         OP_LH:   r = {{16{h[15]}}, h};
         OP_LHU:  r = {16'd0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   assign ea      = Read_data1 + {{16{instruction[15]}}, instruction[15:0]};
   assign cnt_inc = cnt + 8'd1;

   // State register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= 8'd0;
         op_q           <= 6'd0;
         rt_q           <= 5'd0;
         lane_q         <= 2'd0;
         busy           <= 1'b0;
         mem_read       <= 1'b0;
         mem_address    <= 32'd0;
         reg_write      <= 1'b0;
         write_register <= 5'd0;
         write_data     <= 32'd0;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         op_q           <= op_n;
         rt_q           <= rt_n;
         lane_q         <= lane_n;
         busy           <= busy_n;
         mem_read       <= mem_read_n;
         mem_address    <= mem_address_n;
         reg_write      <= reg_write_n;
         write_register <= write_register_n;
         write_data     <= write_data_n;
         done           <= done_n;
         error          <= error_n;
      end
   end

   // Next state and next output values; outputs reflect the state being entered.
   always_comb begin
      state_n          = state;
      cnt_n            = cnt;
      op_n             = op_q;
      rt_n             = rt_q;
      lane_n           = lane_q;
      mem_read_n       = 1'b0;
      mem_address_n    = mem_address;
      reg_write_n      = 1'b0;
      write_register_n = write_register;
      write_data_n     = write_data;
      done_n           = 1'b0;
      error_n          = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               op_n   = instruction[31:26];
               rt_n   = instruction[20:16];
               lane_n = ea[1:0];
               if (!(instruction[31:26] inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU})
                   || (instruction[31:26] == OP_LW && ea[1:0] != 2'b00)
                   || ((instruction[31:26] == OP_LH || instruction[31:26] == OP_LHU)
                       && ea[0])) begin
                  state_n = ERR;
                  done_n  = 1'b1;
                  error_n = 1'b1;
               end else begin
                  state_n       = REQ;
                  cnt_n         = 8'd0;
                  mem_read_n    = 1'b1;
                  mem_address_n = {ea[31:2], 2'b00};
               end
            end
         end
         REQ: begin
            if (mem_ready) begin
               state_n          = WB;
               done_n           = 1'b1;
               reg_write_n      = (rt_q != 5'd0);
               write_register_n = rt_q;
               write_data_n     = extract(op_q, lane_q, mem_rdata);
            end else if (cnt_inc == TMO) begin
               state_n = ERR;
               cnt_n   = cnt_inc;
               done_n  = 1'b1;
               error_n = 1'b1;
            end else begin
               cnt_n      = cnt_inc;
               mem_read_n = 1'b1;
            end
         end
         WB:      state_n = IDLE;
         ERR:     state_n = IDLE;
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: a vector table run through one task, expected
// results queued at start and popped when done is seen, plus hand-written
// sequences for reset state and asynchronous reset during a request.
module tb_load_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] instruction;
   logic [31:0] Read_data1;
   logic        busy;
   logic        mem_read;
   logic [31:0] mem_address;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        reg_write;
   logic [4:0]  write_register;
   logic [31:0] write_data;
   logic        done;
   logic        error;

   int checks   = 0;
   int failures = 0;

   load_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .start(start), .instruction(instruction),
      .Read_data1(Read_data1), .busy(busy), .mem_read(mem_read),
      .mem_address(mem_address), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .reg_write(reg_write), .write_register(write_register),
      .write_data(write_data), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] rs;
      logic [15:0] imm;
      logic [4:0]  rt;
      logic [31:0] rdata;
      int          delay;
      logic        exp_err;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      logic        exp_rw;
      int          exp_lat;
      int          exp_rd;
   } vec_t;

   vec_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v, input bit poke);
      vec_t e;
      int   cyc, nreq;
      bit   got;
      @(negedge clk);
      instruction = {v.op, 5'd1, v.rt, v.imm};
      Read_data1  = v.rs;
      mem_rdata   = v.rdata;
      mem_ready   = 1'b0;
      start       = 1'b1;
      sb.push_back(v);
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; nreq = 0; got = 1'b0;
      while (cyc <= 20 && !got) begin
         if (done) begin
            got = 1'b1;
         end else begin
            if (mem_read) begin
               nreq++;
               chk("mem_address", mem_address, v.exp_addr);
               mem_ready = (nreq > v.delay);
            end else begin
               mem_ready = 1'b0;
            end
            if (poke && cyc == 1) begin
               start       = 1'b1;
               instruction = {6'h20, 5'd2, 5'd1, 16'h0000};
            end else begin
               start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      mem_ready = 1'b0;
      start     = 1'b0;
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL done_wait actual=no_done required=done within 20 cycles");
      end else if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard actual=empty required=entry");
      end else begin
         e = sb.pop_front();
         chk("error", 32'(error), 32'(e.exp_err));
         chk("latency", cyc, e.exp_lat);
         chk("mem_read_cycles", nreq, e.exp_rd);
         chk("reg_write", 32'(reg_write), 32'(e.exp_rw));
         if (!e.exp_err) begin
            chk("write_register", 32'(write_register), 32'(e.rt));
            chk("write_data", write_data, e.exp_data);
         end
         // start coinciding with the done pulse must be dropped
         instruction = {6'h23, 5'd1, 5'd7, 16'h0000};
         Read_data1  = 32'h0000_0800;
         start       = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_done", 32'(done), 32'd0);
         chk("idle_reg_write", 32'(reg_write), 32'd0);
      end
   endtask

   vec_t tbl[14];

   initial begin
      //          op     rs            imm      rt     rdata         dly err addr          data          rw lat rd
      tbl[0]  = '{6'h23, 32'h00000100, 16'h0004, 5'd8,  32'hDEADBEEF, 0, 0, 32'h00000104, 32'hDEADBEEF, 1, 2, 1};
      tbl[1]  = '{6'h20, 32'h00000200, 16'h0003, 5'd9,  32'h80123456, 0, 0, 32'h00000200, 32'hFFFFFF80, 1, 2, 1};
      tbl[2]  = '{6'h24, 32'h00000200, 16'h0003, 5'd9,  32'h80123456, 0, 0, 32'h00000200, 32'h00000080, 1, 2, 1};
      tbl[3]  = '{6'h21, 32'h00000200, 16'h0002, 5'd10, 32'h9ABC0000, 0, 0, 32'h00000200, 32'hFFFF9ABC, 1, 2, 1};
      tbl[4]  = '{6'h25, 32'h00000200, 16'h0002, 5'd10, 32'h9ABC0000, 0, 0, 32'h00000200, 32'h00009ABC, 1, 2, 1};
      tbl[5]  = '{6'h23, 32'h00000010, 16'hFFFC, 5'd3,  32'h12345678, 0, 0, 32'h0000000C, 32'h12345678, 1, 2, 1};
      tbl[6]  = '{6'h23, 32'hFFFFFFFC, 16'h0008, 5'd31, 32'hCAFEF00D, 1, 0, 32'h00000004, 32'hCAFEF00D, 1, 3, 2};
      tbl[7]  = '{6'h23, 32'h00000100, 16'h0002, 5'd4,  32'h0,         0, 1, 32'h0,         32'h0,         0, 1, 0};
      tbl[8]  = '{6'h2B, 32'h00000100, 16'h0000, 5'd4,  32'h0,         0, 1, 32'h0,         32'h0,         0, 1, 0};
      tbl[9]  = '{6'h21, 32'h00000201, 16'h0000, 5'd4,  32'h0,         0, 1, 32'h0,         32'h0,         0, 1, 0};
      tbl[10] = '{6'h23, 32'h00000300, 16'h0000, 5'd0,  32'h11112222, 3, 0, 32'h00000300, 32'h11112222, 0, 5, 4};
      tbl[11] = '{6'h20, 32'h00000400, 16'h0001, 5'd5,  32'h00007F00, 0, 0, 32'h00000400, 32'h0000007F, 1, 2, 1};
      tbl[12] = '{6'h25, 32'h00000400, 16'h0000, 5'd6,  32'h1234F00D, 2, 0, 32'h00000400, 32'h0000F00D, 1, 4, 3};
      tbl[13] = '{6'h23, 32'h00000600, 16'h0000, 5'd7,  32'h0,         99, 1, 32'h00000600, 32'h0,        0, 5, 4};

      reset = 1'b1; start = 1'b0; instruction = 32'd0; Read_data1 = 32'd0;
      mem_ready = 1'b0; mem_rdata = 32'd0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_address", mem_address, 32'd0);
      chk("rst_reg_write", 32'(reg_write), 32'd0);
      chk("rst_write_register", 32'(write_register), 32'd0);
      chk("rst_write_data", write_data, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) run(tbl[i], 1'b0);

      // start pulsed while busy in REQ must not disturb the transaction
      run(tbl[10], 1'b1);
      run(tbl[0], 1'b1);

      // asynchronous reset in the middle of a request
      @(negedge clk);
      instruction = {6'h23, 5'd1, 5'd4, 16'h0000};
      Read_data1  = 32'h0000_0500;
      mem_ready   = 1'b0;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("pre_rst_mem_read", 32'(mem_read), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_mem_read", 32'(mem_read), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("async_rst_done", 32'(done), 32'd0);
      chk("async_rst_reg_write", 32'(reg_write), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run(tbl[0], 1'b0);

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Multi-cycle load datapath block: the read-side counterpart of the store path.
- Decodes a MIPS I-type load and computes the effective address as base + sign-extended imm16.
- Issues one read on a ready-handshaked data-memory port, then extracts and extends the addressed byte, halfword or word.
- Writes the result back through register-file write-port signals. Sits between decode/register read and the data memory.

Parameters:
- TIMEOUT_CYCLES, 255, maximum REQ cycles spent waiting for mem_ready before aborting with error (range 1..255).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  pulse: accept instruction; sampled only in IDLE
- instruction  input  32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:0] imm16
- Read_data1  input  32  base register value (rs), valid with start
- busy  output  1  high in any non-IDLE state
- mem_read  output  1  read request
- mem_address  output  32  effective address, word-aligned ({addr[31:2],2'b00})
- mem_ready  input  1  memory accepts request and mem_rdata is valid (same cycle)
- mem_rdata  input  32  read word, little-endian byte lanes (lane 0 = bits 7:0)
- reg_write  output  1  register-file write enable, one-cycle pulse
- write_register  output  5  destination register (rt)
- write_data  output  32  extended load result
- done  output  1  one-cycle completion pulse
- error  output  1  qualifies done: unsupported opcode, misalignment or timeout

Behaviour:
- All outputs are registered.
- Reset (async): state=IDLE, every output 0, timeout counter 0. Reset during REQ drops mem_read immediately; no writeback occurs.
- Opcodes: LB 0x20 (sign), LH 0x21 (sign), LW 0x23, LBU 0x24 (zero), LHU 0x25 (zero). Any other opcode is unsupported.
- Effective address: Read_data1 + {{16{imm[15]}},imm}, mod 2^32; wrap-around is legal.
- States: IDLE, REQ, WB, ERR.
- IDLE: on start, latch opcode, rt and the effective address.
  - Unsupported opcode -> ERR.
  - LW with addr[1:0]!=0 -> ERR.
  - LH/LHU with addr[0]!=0 -> ERR.
  - Otherwise -> REQ with counter cleared.
- REQ:
  - mem_read=1; mem_address is held stable.
  - mem_ready sampled high -> capture mem_rdata, go to WB.
  - Otherwise the counter increments; when it reaches TIMEOUT_CYCLES -> ERR. mem_read falls on the ERR transition.
- WB:
  - done=1, write_register=rt, write_data=extracted value.
  - reg_write=1 unless rt==0; for rt==0, done still pulses and write_data is still driven.
  - Next cycle -> IDLE.
- Extraction:
  - Byte: lane addr[1:0].
  - Halfword: addr[1]=0 -> bits 15:0, addr[1]=1 -> bits 31:16.
  - Signed loads replicate the MSB of the extracted field; unsigned loads zero-fill.
- ERR: done=1, error=1, reg_write=0 for one cycle; mem_read is never asserted for decode/alignment errors. Next cycle -> IDLE.
- done, error and reg_write are 0 in every cycle outside their pulse. write_data and write_register hold their last values.
- start while busy is ignored (no queueing). start in the same cycle that done pulses is also ignored; it is accepted from the following IDLE cycle.
- Latency, start edge E0 to done high:
  - mem_ready already high in the first REQ cycle: 2 cycles (REQ after E0, WB after E1).
  - Each extra wait cycle adds 1.
  - Decode/alignment error: 1 cycle.

Test Plan:
- LW, Read_data1=0x100, imm=0x0004, rt=8, mem_ready high immediately, mem_rdata=0xDEADBEEF -> mem_address=0x104 one cycle. Then reg_write=1, write_register=8, write_data=0xDEADBEEF, done=1, two cycles after start.
- LB then LBU, address 0x203, mem_rdata=0x80123456 -> write_data 0xFFFFFF80 then 0x00000080. LH then LHU at 0x202 with mem_rdata=0x9ABC0000 -> 0xFFFF9ABC then 0x00009ABC.
- Negative offset: Read_data1=0x10, imm=0xFFFC, LW -> mem_address=0x0000000C. Read_data1=0xFFFFFFFC, imm=0x0008 -> 0x00000004.
- Errors:
  - LW at 0x102 -> done=1, error=1 one cycle after start, mem_read never high, reg_write 0.
  - Opcode 0x2B -> same response.
  - TIMEOUT_CYCLES=4 with mem_ready held low -> mem_read high exactly 4 cycles, then done+error.
- Handshake stall plus rt=0: mem_ready low 3 cycles then high -> mem_address stable throughout, done 5 cycles after start. rt=0 -> done=1, reg_write=0. A start pulse while busy -> no effect.
- Reset asserted asynchronously mid-REQ -> mem_read/busy drop to 0 without waiting for a clock, no done/reg_write. A fresh LW after reset release completes normally.
